// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared state encoding and framebuffer geometry defaults for the sprite blitter
package gpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_SPR,
      ST_FETCH_FB,
      ST_WRITE_FB,
      ST_CLEAR,
      ST_DONE
   } state_t;

   localparam int          SCREEN_W_DEF = 128;
   localparam int          SCREEN_H_DEF = 64;
   localparam logic [11:0] FB_BASE_DEF  = 12'h100;

endpackage

// File: rtl/gpu_blit_addr.sv
// rtl/gpu_blit_addr.sv - maps (x0, y0, row, byte-column, half) to a framebuffer byte address
module gpu_blit_addr
   import gpu_pkg::*;
#(
   parameter int          SCREEN_H  = SCREEN_H_DEF,
   parameter logic [11:0] FB_BASE   = FB_BASE_DEF,
   parameter int          ROW_BYTES = SCREEN_W_DEF / 8
) (
   input  logic [7:0]  i_x0,
   input  logic [7:0]  i_y0,
   input  logic [3:0]  i_r,
   input  logic        i_k,
   input  logic        i_half,
   input  logic        i_clip,
   output logic [11:0] o_fb_addr,
   output logic [2:0]  o_shift,
   output logic        o_on
);

   logic [8:0] w_py_raw;
   logic [8:0] w_py;
   logic [5:0] w_col_raw;
   logic [5:0] w_col;

   always_comb begin
      w_py_raw  = {1'b0, i_y0} + {5'b0, i_r};
      w_col_raw = {1'b0, i_x0[7:3]} + {5'b0, i_k} + {5'b0, i_half};
      // y0 < SCREEN_H and x0 < SCREEN_W, so one subtraction is enough to wrap
      w_py      = (w_py_raw >= 9'(SCREEN_H)) ? w_py_raw - 9'(SCREEN_H) : w_py_raw;
      w_col     = (w_col_raw >= 6'(ROW_BYTES)) ? w_col_raw - 6'(ROW_BYTES) : w_col_raw;
      o_shift   = i_x0[2:0];
      o_on      = !i_clip || ((w_py_raw < 9'(SCREEN_H)) && (w_col_raw < 6'(ROW_BYTES)));
      o_fb_addr = FB_BASE + ({3'b0, w_py} * 12'(ROW_BYTES)) + {6'b0, w_col};
   end

endmodule

// File: rtl/gpu_blit.sv
// rtl/gpu_blit.sv - XOR sprite blitter and framebuffer clear engine on a shared memory port
module gpu_blit
   import gpu_pkg::*;
#(
   parameter int          SCREEN_W  = SCREEN_W_DEF,
   parameter int          SCREEN_H  = SCREEN_H_DEF,
   parameter logic [11:0] FB_BASE   = FB_BASE_DEF,
   parameter int          ROW_BYTES = SCREEN_W / 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_draw,
   input  logic        i_cls,
   input  logic [11:0] i_addr,
   input  logic [3:0]  i_lines,
   input  logic [7:0]  i_x,
   input  logic [7:0]  i_y,
   input  logic        i_clip,
   output logic        o_busy,
   output logic        o_collision,
   output logic        o_mem_read,
   output logic [11:0] o_mem_read_idx,
   input  logic [7:0]  i_mem_read_byte,
   input  logic        i_mem_read_ack,
   output logic        o_mem_write,
   output logic [11:0] o_mem_write_idx,
   output logic [7:0]  o_mem_write_byte
);

   localparam int CLR_BYTES = ROW_BYTES * SCREEN_H;

   state_t      r_state;
   logic        r_busy, r_collision, r_mem_read, r_mem_write;
   logic [11:0] r_mem_read_idx, r_mem_write_idx, r_spr_addr;
   logic [7:0]  r_mem_write_byte, r_spr, r_x0, r_y0;
   logic [3:0]  r_lines, r_row;
   logic        r_k, r_half, r_clip;
   logic [15:0] r_clr_cnt;

   logic [11:0] w_fb_addr;
   logic [2:0]  w_sh;
   logic        w_on, w_wide, w_skip, w_step, w_next_half, w_last, w_next_off, w_final;
   logic [15:0] w_spread;
   logic [7:0]  w_part;

   gpu_blit_addr #(
      .SCREEN_H  (SCREEN_H),
      .FB_BASE   (FB_BASE),
      .ROW_BYTES (ROW_BYTES)
   ) u_addr (
      .i_x0      (r_x0),
      .i_y0      (r_y0),
      .i_r       (r_row),
      .i_k       (r_k),
      .i_half    (r_half),
      .i_clip    (r_clip),
      .o_fb_addr (w_fb_addr),
      .o_shift   (w_sh),
      .o_on      (w_on)
   );

   // high byte of the spread goes to fb column col, low byte to col+1
   assign w_spread    = {r_spr, 8'h00} >> w_sh;
   assign w_part      = r_half ? w_spread[7:0] : w_spread[15:8];
   assign w_skip      = !w_on || (w_part == 8'h00);
   assign w_wide      = (r_lines == 4'd0);
   assign w_last      = (r_row == (w_wide ? 4'd15 : r_lines - 4'd1)) && (r_k == w_wide);
   assign w_next_off  = r_clip && !(w_wide && !r_k) &&
                        (({1'b0, r_y0} + {5'b0, r_row} + 9'd1) >= 9'(SCREEN_H));
   assign w_final     = w_last || w_next_off;
   assign w_next_half = !r_half && (w_sh != 3'd0);
   assign w_step      = ((r_state == ST_FETCH_FB) && !r_mem_read && w_skip) ||
                        (r_state == ST_WRITE_FB);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= ST_IDLE;
         r_busy           <= 1'b0;
         r_collision      <= 1'b0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_read_idx   <= '0;
         r_mem_write_idx  <= '0;
         r_mem_write_byte <= '0;
         r_spr_addr       <= '0;
         r_spr            <= '0;
         r_x0             <= '0;
         r_y0             <= '0;
         r_lines          <= '0;
         r_row            <= '0;
         r_k              <= 1'b0;
         r_half           <= 1'b0;
         r_clip           <= 1'b0;
         r_clr_cnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_cls) begin
                  r_busy    <= 1'b1;
                  r_clr_cnt <= '0;
                  r_state   <= ST_CLEAR;
               end else if (i_draw) begin
                  r_busy         <= 1'b1;
                  r_collision    <= 1'b0;
                  r_spr_addr     <= i_addr;
                  r_mem_read_idx <= i_addr;
                  r_mem_read     <= 1'b1;
                  r_lines        <= i_lines;
                  r_x0           <= 8'(32'(i_x) % SCREEN_W);
                  r_y0           <= 8'(32'(i_y) % SCREEN_H);
                  r_clip         <= i_clip;
                  r_row          <= '0;
                  r_k            <= 1'b0;
                  r_half         <= 1'b0;
                  r_state        <= ST_FETCH_SPR;
               end
            end
            ST_FETCH_SPR: begin
               if (i_mem_read_ack) begin
                  r_mem_read <= 1'b0;
                  r_spr      <= i_mem_read_byte;
                  r_half     <= 1'b0;
                  r_state    <= ST_FETCH_FB;
               end
            end
            ST_FETCH_FB: begin
               // first cycle with no read pending decides skip vs fetch for this half
               if (r_mem_read) begin
                  if (i_mem_read_ack) begin
                     r_mem_read       <= 1'b0;
                     r_mem_write      <= 1'b1;
                     r_mem_write_idx  <= w_fb_addr;
                     r_mem_write_byte <= i_mem_read_byte ^ w_part;
                     if ((i_mem_read_byte & w_part) != 8'h00) r_collision <= 1'b1;
                     r_state          <= ST_WRITE_FB;
                  end
               end else if (!w_skip) begin
                  r_mem_read     <= 1'b1;
                  r_mem_read_idx <= w_fb_addr;
               end
            end
            ST_WRITE_FB: r_mem_write <= 1'b0;
            ST_CLEAR: begin
               if (r_clr_cnt < 16'(CLR_BYTES)) begin
                  r_mem_write      <= 1'b1;
                  r_mem_write_idx  <= FB_BASE + 12'(r_clr_cnt);
                  r_mem_write_byte <= 8'h00;
                  r_clr_cnt        <= r_clr_cnt + 16'd1;
               end else begin
                  r_mem_write <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         if (w_step) begin
            if (w_next_half) begin
               r_half  <= 1'b1;
               r_state <= ST_FETCH_FB;
            end else if (w_final) begin
               r_busy  <= 1'b0;
               r_state <= ST_DONE;
            end else begin
               if (w_wide && !r_k) begin
                  r_k <= 1'b1;
               end else begin
                  r_k   <= 1'b0;
                  r_row <= r_row + 4'd1;
               end
               r_spr_addr     <= r_spr_addr + 12'd1;
               r_mem_read_idx <= r_spr_addr + 12'd1;
               r_mem_read     <= 1'b1;
               r_state        <= ST_FETCH_SPR;
            end
         end
      end
   end

   assign o_busy           = r_busy;
   assign o_collision      = r_collision;
   assign o_mem_read       = r_mem_read;
   assign o_mem_read_idx   = r_mem_read_idx;
   assign o_mem_write      = r_mem_write;
   assign o_mem_write_idx  = r_mem_write_idx;
   assign o_mem_write_byte = r_mem_write_byte;

endmodule

// File: tb/tb_gpu_blit.sv
// tb/tb_gpu_blit.sv - self-checking bench for gpu_blit against a pixel-level framebuffer model
module tb_gpu_blit;

   localparam int W   = 128;
   localparam int H   = 64;
   localparam int RB  = W / 8;
   localparam int FB  = 256;
   localparam int FBN = RB * H;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        draw = 1'b0, cls = 1'b0, clip = 1'b0;
   logic [11:0] addr = '0;
   logic [3:0]  lines = '0;
   logic [7:0]  x = '0, y = '0;
   logic        busy, collision, mem_read, mem_write;
   logic [11:0] mem_read_idx, mem_write_idx;
   logic [7:0]  mem_write_byte;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ack = 1'b0;

   logic [7:0]  spr_mem [4096];
   logic [7:0]  fbm [FBN];
   logic [7:0]  mdl [FBN];
   int          n_cmp = 0, n_fail = 0, n_excl = 0, n_stray = 0, wait_cnt = 0;
   bit          seeded = 0;

   gpu_blit dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_draw           (draw),
      .i_cls            (cls),
      .i_addr           (addr),
      .i_lines          (lines),
      .i_x              (x),
      .i_y              (y),
      .i_clip           (clip),
      .o_busy           (busy),
      .o_collision      (collision),
      .o_mem_read       (mem_read),
      .o_mem_read_idx   (mem_read_idx),
      .i_mem_read_byte  (mem_rdata),
      .i_mem_read_ack   (mem_ack),
      .o_mem_write      (mem_write),
      .o_mem_write_idx  (mem_write_idx),
      .o_mem_write_byte (mem_write_byte)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [11:0] a);
      if (int'(a) >= FB && int'(a) < FB + FBN) return fbm[int'(a) - FB];
      return spr_mem[int'(a)];
   endfunction

   // memory: random read latency, writes land at the negedge they are seen
   always @(negedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < FBN; i++) fbm[i] = 8'($urandom);
         seeded = 1;
      end
      if (mem_read && mem_write) n_excl++;
      if (mem_write) begin
         if (int'(mem_write_idx) >= FB && int'(mem_write_idx) < FB + FBN)
            fbm[int'(mem_write_idx) - FB] = mem_write_byte;
         else
            n_stray++;
      end
      if (!rst_n) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_read) begin
         if (wait_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = rd(mem_read_idx);
            wait_cnt  = $urandom_range(0, 2);
         end else begin
            wait_cnt--;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_fb(input string nm);
      int bad = 0, first = -1;
      for (int i = 0; i < FBN; i++)
         if (fbm[i] !== mdl[i]) begin
            if (first < 0) first = i;
            bad++;
         end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d fb bytes differ, first at %03h got %02h expected %02h",
                  nm, bad, FB + first, fbm[first], mdl[first]);
      end
   endtask

   // pixel-level reference: bit 7 of a byte is the leftmost pixel
   task automatic model_draw(input logic [11:0] a, input logic [3:0] ln, input logic [7:0] xx,
                             input logic [7:0] yy, input bit cl, output bit coll);
      int rows, bpr, x0, y0, px, py, off, b;
      logic [7:0] s;
      rows = (ln == 0) ? 16 : int'(ln);
      bpr  = (ln == 0) ? 2 : 1;
      x0   = int'(xx) % W;
      y0   = int'(yy) % H;
      coll = 0;
      for (int r = 0; r < rows; r++)
         for (int j = 0; j < 8 * bpr; j++) begin
            s = spr_mem[(int'(a) + r * bpr + j / 8) % 4096];
            if (s[7 - (j % 8)]) begin
               px = x0 + j;
               py = y0 + r;
               if (!(cl && (px >= W || py >= H))) begin
                  px  = px % W;
                  py  = py % H;
                  off = py * RB + px / 8;
                  b   = 7 - (px % 8);
                  if (mdl[off][b]) coll = 1;
                  mdl[off][b] = ~mdl[off][b];
               end
            end
         end
   endtask

   task automatic start_cmd(input bit d, input bit c, input logic [11:0] a, input logic [3:0] ln,
                            input logic [7:0] xx, input logic [7:0] yy, input bit cl);
      @(negedge clk);
      draw = d; cls = c; addr = a; lines = ln; x = xx; y = yy; clip = cl;
      @(posedge clk);
      #1;
      chk("busy_rise", busy, 1);
      draw = 1'b0;
      cls  = 1'b0;
   endtask

   task automatic wait_idle(input bit poke, output int cyc);
      cyc = 0;
      while (busy && cyc < 6000) begin
         if (poke && cyc == 100) begin
            addr = 12'h042; lines = 4'd5; x = 8'd0; y = 8'd0; draw = 1'b1;
         end
         if (poke && cyc == 101) draw = 1'b0;
         cyc++;
         @(posedge clk);
         #1;
      end
      draw = 1'b0;
      if (busy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_draw(input string nm, input logic [11:0] a, input logic [3:0] ln,
                          input logic [7:0] xx, input logic [7:0] yy, input bit cl);
      bit ce;
      int cyc;
      model_draw(a, ln, xx, yy, cl, ce);
      start_cmd(1, 0, a, ln, xx, yy, cl);
      wait_idle(0, cyc);
      cmp_fb(nm);
      chk({nm, "_coll"}, collision, ce);
   endtask

   task automatic do_cls(input string nm, input bit poke, input bit with_draw);
      int cyc;
      for (int i = 0; i < FBN; i++) mdl[i] = 8'h00;
      start_cmd(with_draw, 1, 12'h042, 4'd5, 8'd0, 8'd0, 1'b0);
      wait_idle(poke, cyc);
      chk({nm, "_busy_cycles_ok"}, (cyc >= 1020 && cyc <= 1030), 1);
      cmp_fb(nm);
   endtask

   typedef struct {
      bit          do_cls;
      logic [3:0]  lines;
      logic [7:0]  x, y;
      logic        clip;
      logic [7:0]  spr [5];
      int          n;
      logic [11:0] ea [5];
      logic [7:0]  ev [5];
      logic        coll;
   } vec_t;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [5];
      int   bad;
      tbl[0] = '{do_cls:1'b1, lines:4'd5, x:8'd0, y:8'd0, clip:1'b0,
                 spr:'{8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hFF}, n:5,
                 ea:'{12'h100, 12'h110, 12'h120, 12'h130, 12'h140},
                 ev:'{8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hFF}, coll:1'b0};
      tbl[1] = '{do_cls:1'b0, lines:4'd5, x:8'd0, y:8'd0, clip:1'b0,
                 spr:'{8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hFF}, n:5,
                 ea:'{12'h100, 12'h110, 12'h120, 12'h130, 12'h140},
                 ev:'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, coll:1'b1};
      tbl[2] = '{do_cls:1'b0, lines:4'd1, x:8'd3, y:8'd0, clip:1'b0,
                 spr:'{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, n:2,
                 ea:'{12'h100, 12'h101, 12'h000, 12'h000, 12'h000},
                 ev:'{8'h1F, 8'hE0, 8'h00, 8'h00, 8'h00}, coll:1'b0};
      tbl[3] = '{do_cls:1'b1, lines:4'd2, x:8'd124, y:8'd63, clip:1'b0,
                 spr:'{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, n:4,
                 ea:'{12'h4FF, 12'h4F0, 12'h10F, 12'h100, 12'h000},
                 ev:'{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h00}, coll:1'b0};
      tbl[4] = '{do_cls:1'b1, lines:4'd2, x:8'd124, y:8'd63, clip:1'b1,
                 spr:'{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, n:4,
                 ea:'{12'h4FF, 12'h4F0, 12'h10F, 12'h100, 12'h000},
                 ev:'{8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, coll:1'b0};

      for (int i = 0; i < 4096; i++) spr_mem[i] = 8'($urandom);

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_collision", collision, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_idx_data", {mem_read_idx, mem_write_idx, mem_write_byte}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_cls("cls_dirty_poke_draw", 1, 0);

      for (int v = 0; v < 5; v++) begin
         if (tbl[v].do_cls) do_cls($sformatf("vec%0d_cls", v), 0, 0);
         for (int i = 0; i < int'(tbl[v].lines); i++) spr_mem[12'h042 + i] = tbl[v].spr[i];
         do_draw($sformatf("vec%0d", v), 12'h042, tbl[v].lines, tbl[v].x, tbl[v].y, tbl[v].clip);
         for (int i = 0; i < tbl[v].n; i++)
            chk($sformatf("vec%0d_byte_%03h", v, tbl[v].ea[i]),
                fbm[int'(tbl[v].ea[i]) - FB], tbl[v].ev[i]);
         chk($sformatf("vec%0d_collision", v), collision, tbl[v].coll);
      end

      do_cls("cls_wins", 0, 1);

      for (int i = 0; i < 32; i++) spr_mem[12'h042 + i] = 8'hFF;
      do_draw("wide", 12'h042, 4'd0, 8'd0, 8'd0, 1'b0);
      bad = 0;
      for (int r = 0; r < 16; r++)
         for (int k = 0; k < 2; k++)
            if (fbm[r * RB + k] !== 8'hFF) bad++;
      chk("wide_ff_bytes_wrong", bad, 0);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            do_cls($sformatf("rnd%0d_cls", it), 0, 0);
         end else begin
            logic [11:0] a;
            logic [3:0]  ln;
            int          nb;
            a  = 12'($urandom_range(0, 223));
            ln = 4'($urandom);
            nb = (ln == 0) ? 32 : int'(ln);
            for (int i = 0; i < nb; i++)
               spr_mem[int'(a) + i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            do_draw($sformatf("rnd%0d", it), a, ln, 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)));
         end
      end

      begin
         int n = 0;
         start_cmd(1, 0, 12'h042, 4'd0, 8'd5, 8'd5, 1'b0);
         while (!mem_write && n < 200) begin
            n++;
            @(posedge clk);
            #1;
         end
         chk("abort_saw_write", mem_write, 1);
         @(posedge clk);
         #2;
         rst_n = 1'b0;
         #1;
         chk("abort_busy", busy, 0);
         chk("abort_mem_read", mem_read, 0);
         chk("abort_mem_write", mem_write, 0);
         @(negedge clk);
         rst_n = 1'b1;
         do_cls("cls_after_abort", 0, 0);
      end

      chk("read_write_overlap_cycles", n_excl, 0);
      chk("writes_outside_fb", n_stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
